// File: rtl/lc3_fetch_prefetch_if.sv
// Fetch-stage bundle: instruction-memory request/response port, decode handshake,
// branch redirect and the sticky error flag.
interface lc3_fetch_prefetch_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          br_taken;
    logic [AW-1:0] taddr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          err;

    modport master (
        input  br_taken, taddr, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, pc, npc, err
    );

    modport slave (
        output br_taken, taddr, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, pc, npc, err
    );
endinterface

// File: rtl/lc3_fetch_prefetch.sv
// LC3 prefetching fetch stage: sequential request issue, in-order response capture
// into a DEPTH-entry instruction queue, and redirect with in-flight response discard.
module lc3_fetch_prefetch #(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter int            DEPTH    = 4,
    parameter int            MAX_OUT  = 4,
    parameter logic [AW-1:0] RESET_PC = 16'h3000
) (
    input  logic                clk,
    input  logic                rst,
    lc3_fetch_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(MAX_OUT + 1);
    localparam int SW = ((CW > LW) ? CW : LW) + 1;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] live_q, live_d;
    logic [LW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [AW-1:0] pcs_q  [DEPTH];
    logic [AW-1:0] pcs_d  [DEPTH];
    logic          err_q, err_d;

    logic          issue, head_valid, grant, pop, push, drop, spurious;
    logic [SW-1:0] occupancy, inflight;

    // Queue space is reserved at issue time (count+live), so a push can never overflow.
    always_comb begin
        occupancy  = SW'(count_q) + SW'(live_q);
        inflight   = SW'(live_q) + SW'(discard_q);
        issue      = !rst && !bus.br_taken && (occupancy < SW'(DEPTH)) && (inflight < SW'(MAX_OUT));
        head_valid = (count_q != '0) && !bus.br_taken;
        grant      = issue && bus.mem_gnt;
        pop        = head_valid && bus.instr_ready;
        drop       = bus.mem_rvalid && (discard_q != '0);
        push       = bus.mem_rvalid && (discard_q == '0) && (live_q != '0);
        spurious   = bus.mem_rvalid && (discard_q == '0) && (live_q == '0);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        live_d     = live_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        data_d     = data_q;
        pcs_d      = pcs_q;
        err_d      = err_q | spurious;

        if (bus.br_taken) begin
            // Everything outstanding becomes discard, minus a response landing right now.
            fetch_pc_d = bus.taddr;
            resp_pc_d  = bus.taddr;
            count_d    = '0;
            live_d     = '0;
            rd_ptr_d   = wr_ptr_q;
            discard_d  = LW'(inflight - SW'(drop || push));
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + AW'(1);
            end
            if (push) begin
                data_d[wr_ptr_q] = bus.mem_rdata;
                pcs_d[wr_ptr_q]  = resp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                resp_pc_d        = resp_pc_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (drop) begin
                discard_d = discard_q - LW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            live_d  = live_q + LW'(grant) - LW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            live_q     <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= RESET_PC;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            live_q     <= live_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
            data_q     <= data_d;
            pcs_q      <= pcs_d;
        end
    end

    assign bus.mem_req     = issue;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = data_q[rd_ptr_q];
    assign bus.pc          = pcs_q[rd_ptr_q];
    assign bus.npc         = pcs_q[rd_ptr_q] + AW'(1);
    assign bus.err         = err_q;
endmodule

// File: doc/lc3_fetch_prefetch.md
Name: lc3_fetch_prefetch

Overview:
- Parametrised successor to the LC3 fetch stage.
- Generates sequential instruction addresses, issues requests to instruction memory over a request/grant port, and accepts in-order responses with arbitrary latency.
- Buffers fetched instructions with their PC/NPC in a DEPTH-entry queue feeding decode over a valid/ready handshake.
- Branch redirect (br_taken/taddr) flushes the queue and discards in-flight responses.

Parameters:
- AW, 16, address/PC width.
- DW, 16, instruction width.
- DEPTH, 4, instruction queue entries (power of 2, ≥2).
- MAX_OUT, 4, max memory requests in flight, live plus discarded (≥1).
- RESET_PC, 16'h3000, PC after reset.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- br_taken  input  1  redirect strobe, one cycle.
- taddr  input  AW  redirect target, sampled when br_taken=1.
- mem_req  output  1  fetch request valid.
- mem_addr  output  AW  fetch address (= fetch_pc).
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  response data valid (in request order).
- mem_rdata  input  DW  response instruction.
- instr_valid  output  1  queue head valid to decode.
- instr_ready  input  1  decode accepts head.
- instr  output  DW  head instruction.
- pc  output  AW  head instruction address.
- npc  output  AW  pc+1 mod 2^AW.
- err  output  1  sticky protocol error.

Behaviour:
- Reset, synchronous and active-high:
  - fetch_pc=resp_pc=RESET_PC.
  - Queue, live and discard counters cleared; err=0.
  - Outputs next cycle: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, pc=RESET_PC, npc=RESET_PC+1.
  - Reset mid-operation drops everything.
  - Memory is reset by the same rst, so no pre-reset responses arrive afterwards.
- Request issue:
  - mem_req=1 iff !rst && !br_taken && (count+live)<DEPTH && (live+discard)<MAX_OUT.
  - The first condition reserves queue space, so the queue can never overflow.
  - On mem_req&&mem_gnt: fetch_pc<=fetch_pc+1 (wraps mod 2^AW) and live++.
  - mem_addr holds stable while mem_req=1 && !mem_gnt.
- Response, mem_rvalid=1:
  - If discard>0: decrement discard, drop data.
  - Else if live>0: push {mem_rdata, resp_pc}, resp_pc<=resp_pc+1, live--.
  - Else: set err=1 (sticky until rst), drop data.
  - Grant and response in the same cycle: live is net unchanged.
- Latency: response at cycle N gives instr_valid at N+1 if the queue was empty. Minimum grant-to-decode is 2 cycles with 1-cycle memory.
- Dequeue:
  - instr_valid = (count>0) && !br_taken.
  - Pop on instr_valid&&instr_ready.
  - instr/pc/npc are head fields; npc = pc+1 mod 2^AW.
  - Simultaneous push and pop: count unchanged, FIFO order kept; a push into an empty queue is not poppable in the same cycle.
- Redirect, br_taken=1:
  - Queue flushed (count<=0).
  - fetch_pc<=taddr, resp_pc<=taddr.
  - discard <= discard+live, less 1 if mem_rvalid this cycle (that response is dropped); live<=0.
  - mem_req is forced 0 that cycle, so no grant is taken; instr_valid is forced 0, so no pop.
  - Issue resumes next cycle from taddr.
  - Back-to-back redirects: the last taddr wins and discard accumulates.
- Redirect together with rst: rst wins.
- Counter widths:
  - count holds 0..DEPTH.
  - live and discard hold 0..MAX_OUT; live+discard ≤ MAX_OUT is invariant.
- Must never occur:
  - pop on empty;
  - push with count=DEPTH;
  - mem_req=1 while live+discard=MAX_OUT.

Test Plan:
- Steady stream: rst, then mem_gnt=1, rvalid one cycle after each grant, instr_ready=1 -> pc=3000,3001,3002… on consecutive cycles, npc=pc+1, first instr_valid 2 cycles after first grant.
- Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 grants then mem_req=0 with count=4. Raise ready -> heads drain in order 3000..3003 and mem_req re-asserts the cycle after the first pop.
- Redirect with 2 in flight: br_taken with taddr=4000 -> next 2 rvalids dropped, mem_addr=4000 next cycle, first post-redirect head pc=4000, no stale entry ever visible.
- Redirect coincident with rvalid and a pop attempt: that response dropped, no pop, discard=live-1, subsequent stream correct from taddr.
- Wrap: RESET_PC=FFFE -> mem_addr FFFE, FFFF, 0000; pc at FFFF gives npc=0000.
- Spurious rvalid with live=discard=0 -> err=1 and stays 1; rst mid-stream -> all outputs at reset values next cycle, err=0.
